playback_ctrl: RTL



---
 rtl/playback_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/playback_ctrl.sv
// Playback sequencer: lock-stable, flush, prefill, play, with recovery on lock loss, rate change and underrun.
// Optional feature macro: PLAYBACK_CTRL_UNDERRUN_EN (underrun detection, counting and PLAY-to-FLUSH recovery).
module playback_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 24576,
  parameter int FLUSH_CYCLES       = 32,
  parameter int PREFILL_CYCLES     = 256,
  parameter int UNDERRUN_CYCLES    = 64,
  parameter int CNT_W              = 16
) (
  input  logic       clk245760,
  input  logic       rst,
  input  logic       locked_i,
  input  logic [4:0] rate_i,
  input  logic       fifo_empty_i,
  output logic       fifo_rst_o,
  output logic       pop_en_o,
  output logic       dac_mute_o,
  output logic       led_locked_o,
  output logic [2:0] state_o,
  output logic [7:0] underrun_cnt_o
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    FLUSH     = 3'd2,
    PREFILL   = 3'd3,
    PLAY      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LOAD    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PREFILL_LOAD = CNT_W'(PREFILL_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             pre_run, pre_run_nx;
  logic [1:0]       lock_sync, empty_sync;
  logic [4:0]       rate_meta, rate_s, rate_q;
  logic             lock_s, empty_s;
  logic             rate_diff, rate_seen, rate_chg, rate_ld;

  assign lock_s  = lock_sync[1];
  assign empty_s = empty_sync[1];

  always_ff @(posedge clk245760) begin
    if (rst) begin
      lock_sync  <= '0;
      empty_sync <= '0;
      rate_meta  <= '0;
      rate_s     <= '0;
    end else begin
      lock_sync  <= {lock_sync[0], locked_i};
      empty_sync <= {empty_sync[0], fifo_empty_i};
      rate_meta  <= rate_i;
      rate_s     <= rate_meta;
    end
  end

  // A rate change needs the mismatch on two consecutive cycles to reject multi-bit skew.
  assign rate_diff = (rate_s != rate_q);
  assign rate_chg  = rate_diff && rate_seen;
  assign rate_ld   = rate_chg || ((state == WAIT_LOCK) && lock_s);

  always_ff @(posedge clk245760) begin
    if (rst) begin
      rate_q    <= '0;
      rate_seen <= 1'b0;
    end else begin
      rate_seen <= rate_diff && !rate_chg;
      if (rate_ld) rate_q <= rate_s;
    end
  end

`ifdef PLAYBACK_CTRL_UNDERRUN_EN
  localparam logic [CNT_W-1:0] UNDER_LAST = CNT_W'(UNDERRUN_CYCLES - 1);
  logic [CNT_W-1:0] run, run_nx;
  logic             underrun;

  always_ff @(posedge clk245760) begin
    if (rst) begin
      run            <= '0;
      underrun_cnt_o <= '0;
    end else begin
      run <= run_nx;
      if (underrun && (underrun_cnt_o != '1)) underrun_cnt_o <= underrun_cnt_o + 8'd1;
    end
  end
`else
  assign underrun_cnt_o = '0;
`endif

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    pre_run_nx = 1'b0;
`ifdef PLAYBACK_CTRL_UNDERRUN_EN
    run_nx     = '0;
    underrun   = 1'b0;
`endif
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = STABLE;
          timer_nx = LOCK_LOAD;
        end
      end
      STABLE, FLUSH, PREFILL, PLAY: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (rate_chg) begin
          state_nx = STABLE;
          timer_nx = LOCK_LOAD;
        end else begin
          case (state)
            STABLE: begin
              if (timer == '0) begin
                state_nx = FLUSH;
                timer_nx = FLUSH_LOAD;
              end else begin
                timer_nx = timer - CNT_W'(1);
              end
            end
            FLUSH: begin
              if (timer == '0) state_nx = PREFILL;
              else timer_nx = timer - CNT_W'(1);
            end
            PREFILL: begin
              if (!pre_run) begin
                if (!empty_s) begin
                  timer_nx   = PREFILL_LOAD;
                  pre_run_nx = 1'b1;
                end
              end else if (timer == '0) begin
                state_nx = PLAY;
              end else begin
                timer_nx   = timer - CNT_W'(1);
                pre_run_nx = 1'b1;
              end
            end
            PLAY: begin
`ifdef PLAYBACK_CTRL_UNDERRUN_EN
              if (empty_s) begin
                if (run == UNDER_LAST) begin
                  underrun = 1'b1;
                  state_nx = FLUSH;
                  timer_nx = FLUSH_LOAD;
                end else begin
                  run_nx = run + CNT_W'(1);
                end
              end
`endif
            end
            default: ;
          endcase
        end
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as state_o.
  always_ff @(posedge clk245760) begin
    if (rst) begin
      state        <= WAIT_LOCK;
      timer        <= '0;
      pre_run      <= 1'b0;
      fifo_rst_o   <= 1'b1;
      pop_en_o     <= 1'b0;
      dac_mute_o   <= 1'b1;
      led_locked_o <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      pre_run      <= pre_run_nx;
      fifo_rst_o   <= (state_nx == WAIT_LOCK) || (state_nx == STABLE) || (state_nx == FLUSH);
      pop_en_o     <= (state_nx == PLAY);
      dac_mute_o   <= (state_nx != PLAY);
      led_locked_o <= lock_s;
    end
  end

  assign state_o = state;

endmodule
